fetch_stage: RTL and testbench

- IF stage: owns the PC, issues instruction fetches on the ibus and presents one fetched instruction per handshake to the IF/ID register.
- Handles downstream stalls with a one-entry hold buffer.
- Handles branch/exception redirects, including a redirect that arrives while a bus request is outstanding, which the bus cannot abort.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC; issues ibus fetches, holds one instruction across
// downstream stalls and drops responses made stale by redirects.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned PC raises out_exc instead of fetching.
module fetch_stage #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_exc,
  output logic            fetch_busy
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} stateT;
  stateT state;
  logic [XLEN-1:0] pc, pendingPc;
  logic [31:0] buffer;
  logic misalign, trapShow;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic trapDone;
  assign misalign = (state == FETCH) && (pc[1:0] != 2'b00);
  assign trapShow = misalign && !trapDone;
  // Remember that the trap instruction was accepted so it is presented only once per redirect
  always_ff @(posedge clk)
    trapDone <= !reset && misalign && !redirect_valid && (trapDone || !stall);
`else
  assign misalign = 1'b0;
  assign trapShow = 1'b0;
`endif
  // Bus request and IF/ID presentation; a redirect always suppresses out_valid
  always_comb begin
    out_pc = reset ? RESET_PC : pc;
    ireq_addr = out_pc;
    ireq_valid = !reset && ((state == FETCH && !misalign) || state == DISCARD);
    fetch_busy = ireq_valid;
    out_valid = !reset && !redirect_valid &&
                ((state == FETCH && !misalign && iresp_data_ok) || state == HOLD || trapShow);
    out_instr = !out_valid ? 32'h0 : state == HOLD ? buffer : trapShow ? 32'h0000_0013 : iresp_data;
    out_exc = out_valid && trapShow;
  end
  // PC / hold-buffer state machine: redirect beats stall beats normal progress
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      state <= FETCH;
      buffer <= 32'h0;
      pendingPc <= '0;
    end else
      case (state)
        FETCH:
          if (misalign) begin
            if (redirect_valid) pc <= redirect_pc;
          end else if (iresp_data_ok) begin
            if (redirect_valid) pc <= redirect_pc;
            else if (stall) begin
              buffer <= iresp_data;
              state <= HOLD;
            end else pc <= pc + XLEN'(4);
          end else if (redirect_valid) begin
            pendingPc <= redirect_pc;
            state <= DISCARD;
          end
        HOLD:
          if (redirect_valid) begin
            pc <= redirect_pc;
            state <= FETCH;
          end else if (!stall) begin
            pc <= pc + XLEN'(4);
            state <= FETCH;
          end
        DISCARD:
          if (iresp_data_ok) begin
            pc <= redirect_valid ? redirect_pc : pendingPc;
            state <= FETCH;
          end else if (redirect_valid) pendingPc <= redirect_pc;
        default: state <= FETCH;
      endcase
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_stage;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ireq_valid;
  logic [63:0] ireq_addr;
  logic iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic stall = 1'b0;
  logic out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic out_exc;
  logic fetch_busy;
  int passed = 0;
  int total = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_exc(out_exc), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
  endfunction

  // Apply one cycle of inputs just after the edge; returns mid-cycle for sampling.
  task automatic drive(input logic ok, input logic [31:0] d, input logic rv,
                       input logic [63:0] rp, input logic st);
    @(posedge clk);
    #1;
    iresp_data_ok = ok;
    iresp_data = d;
    redirect_valid = rv;
    redirect_pc = rp;
    stall = st;
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 32'h0, 0, 64'h0, 0);
    drive(1, 32'hDEAD_BEEF, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (ireq_valid !== 1'b0) $display("FAIL reset_ireq_valid got %b want 0", ireq_valid); else passed++;
    total++; if (out_exc !== 1'b0) $display("FAIL reset_out_exc got %b want 0", out_exc); else passed++;
    total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr got %h want 0", out_instr); else passed++;
    total++; if (out_pc !== RESET_PC) $display("FAIL reset_out_pc got %h want %h", out_pc, RESET_PC); else passed++;
    total++; if (fetch_busy !== 1'b0) $display("FAIL reset_fetch_busy got %b want 0", fetch_busy); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    iresp_data_ok = 1'b0;
    #3;
    total++; if (ireq_valid !== 1'b1) $display("FAIL post_reset_req got %b want 1", ireq_valid); else passed++;
    total++; if (ireq_addr !== RESET_PC) $display("FAIL post_reset_addr got %h want %h", ireq_addr, RESET_PC); else passed++;
    total++; if (fetch_busy !== 1'b1) $display("FAIL post_reset_busy got %b want 1", fetch_busy); else passed++;
  endtask

  task automatic test_basic();
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_wait_valid got %b want 0", out_valid); else passed++;
    drive(1, 32'h0000_0513, 0, 64'h0, 0);
    total++; if (ireq_addr !== 64'h8000_0000) $display("FAIL basic_addr got %h want 80000000", ireq_addr); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else passed++;
    total++; if (out_pc !== 64'h8000_0000) $display("FAIL basic_pc got %h want 80000000", out_pc); else passed++;
    total++; if (out_instr !== 32'h0000_0513) $display("FAIL basic_instr got %h want 00000513", out_instr); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_addr !== 64'h8000_0004) $display("FAIL basic_next_addr got %h want 80000004", ireq_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_next_valid got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    drive(1, 32'h0010_0093, 0, 64'h0, 1);
    total++; if (out_valid !== 1'b1) $display("FAIL stall_first_valid got %b want 1", out_valid); else passed++;
    total++; if (out_instr !== 32'h0010_0093) $display("FAIL stall_first_instr got %h want 00100093", out_instr); else passed++;
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 0, 64'h0, 1);
      total++; if (out_valid !== 1'b1) $display("FAIL stall_hold_valid got %b want 1", out_valid); else passed++;
      total++; if (out_instr !== 32'h0010_0093) $display("FAIL stall_hold_instr got %h want 00100093", out_instr); else passed++;
      total++; if (ireq_valid !== 1'b0) $display("FAIL stall_hold_req got %b want 0", ireq_valid); else passed++;
      total++; if (out_pc !== 64'h8000_0004) $display("FAIL stall_hold_pc got %h want 80000004", out_pc); else passed++;
    end
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL stall_release_valid got %b want 1", out_valid); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_valid !== 1'b1) $display("FAIL stall_next_req got %b want 1", ireq_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_0008) $display("FAIL stall_next_addr got %h want 80000008", ireq_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL stall_no_dup got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_redirect_discard();
    drive(0, 32'h0, 1, 64'h8000_1000, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL disc_redir_valid got %b want 0", out_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_0008) $display("FAIL disc_redir_addr got %h want 80000008", ireq_addr); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_valid !== 1'b1) $display("FAIL disc_req got %b want 1", ireq_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_0008) $display("FAIL disc_addr got %h want 80000008", ireq_addr); else passed++;
    total++; if (fetch_busy !== 1'b1) $display("FAIL disc_busy got %b want 1", fetch_busy); else passed++;
    drive(1, 32'h1111_1111, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL disc_drop_valid got %b want 0", out_valid); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_addr !== 64'h8000_1000) $display("FAIL disc_next_addr got %h want 80001000", ireq_addr); else passed++;
  endtask

  task automatic test_double_redirect();
    drive(0, 32'h0, 1, 64'h8000_2000, 0);
    drive(0, 32'h0, 1, 64'h8000_3000, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL dbl_valid got %b want 0", out_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_1000) $display("FAIL dbl_old_addr got %h want 80001000", ireq_addr); else passed++;
    drive(1, 32'h2222_2222, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL dbl_drop_valid got %b want 0", out_valid); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_addr !== 64'h8000_3000) $display("FAIL dbl_next_addr got %h want 80003000", ireq_addr); else passed++;
  endtask

  task automatic test_redirect_dataok_stall();
    drive(1, 32'h3333_3333, 1, 64'h8000_4000, 1);
    total++; if (out_valid !== 1'b0) $display("FAIL rds_valid got %b want 0", out_valid); else passed++;
    drive(0, 32'h0, 0, 64'h0, 1);
    total++; if (ireq_valid !== 1'b1) $display("FAIL rds_req got %b want 1", ireq_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_4000) $display("FAIL rds_addr got %h want 80004000", ireq_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rds_no_hold got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_wrap();
    drive(1, 32'h4444_4444, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    drive(1, 32'h0000_0073, 0, 64'h0, 0);
    total++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffffffffffc", out_pc); else passed++;
    total++; if (out_instr !== 32'h0000_0073) $display("FAIL wrap_instr got %h want 00000073", out_instr); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (ireq_addr !== 64'h0) $display("FAIL wrap_addr got %h want 0", ireq_addr); else passed++;
  endtask

  task automatic test_misalign();
    drive(1, 32'h5555_5555, 1, 64'h8000_0002, 0);
    drive(0, 32'h0, 0, 64'h0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (ireq_valid !== 1'b0) $display("FAIL mis_req got %b want 0", ireq_valid); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL mis_valid got %b want 1", out_valid); else passed++;
    total++; if (out_exc !== 1'b1) $display("FAIL mis_exc got %b want 1", out_exc); else passed++;
    total++; if (out_instr !== 32'h0000_0013) $display("FAIL mis_instr got %h want 00000013", out_instr); else passed++;
    total++; if (out_pc !== 64'h8000_0002) $display("FAIL mis_pc got %h want 80000002", out_pc); else passed++;
    drive(0, 32'h0, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL mis_once got %b want 0", out_valid); else passed++;
`else
    total++; if (ireq_valid !== 1'b1) $display("FAIL mis_req got %b want 1", ireq_valid); else passed++;
    total++; if (ireq_addr !== 64'h8000_0002) $display("FAIL mis_addr got %h want 80000002", ireq_addr); else passed++;
    drive(1, 32'h6666_6666, 0, 64'h0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL mis_valid got %b want 1", out_valid); else passed++;
    total++; if (out_exc !== 1'b0) $display("FAIL mis_exc got %b want 0", out_exc); else passed++;
    total++; if (out_pc !== 64'h8000_0002) $display("FAIL mis_pc got %h want 80000002", out_pc); else passed++;
`endif
  endtask

  // Model: expPc is the next instruction owed to IF/ID; a response is stale if any redirect
  // arrived while it was outstanding; an unaccepted instruction stays presented until taken.
  task automatic test_random();
    logic [63:0] expPc, reqAddr, rp;
    bit outstanding, hold, dirty, ok, rv, st, ev;
    int waitCnt;
    @(posedge clk);
    #1;
    reset = 1'b1;
    iresp_data_ok = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expPc = RESET_PC;
    reqAddr = 64'h0;
    outstanding = 0;
    hold = 0;
    dirty = 0;
    waitCnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      total++; if (ireq_valid !== !hold) $display("FAIL rnd_req_valid cyc %0d got %b want %b", c, ireq_valid, !hold); else passed++;
      if (!outstanding && ireq_valid === 1'b1) begin
        outstanding = 1;
        reqAddr = ireq_addr;
        waitCnt = $urandom_range(1, 3);
        total++; if (ireq_addr !== expPc) $display("FAIL rnd_req_addr cyc %0d got %h want %h", c, ireq_addr, expPc); else passed++;
      end else if (outstanding) begin
        total++; if (ireq_addr !== reqAddr) $display("FAIL rnd_addr_stable cyc %0d got %h want %h", c, ireq_addr, reqAddr); else passed++;
      end
      ok = outstanding && waitCnt == 0;
      if (outstanding && waitCnt > 0) waitCnt--;
      st = $urandom_range(0, 2) == 0;
      rv = $urandom_range(0, 7) == 0;
      rp = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                        : {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      iresp_data_ok = ok;
      iresp_data = ok ? mem(reqAddr) : $urandom;
      redirect_valid = rv;
      redirect_pc = rp;
      stall = st;
      #3;
      ev = !rv && (hold || (ok && !dirty));
      total++; if (out_valid !== ev) $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, ev); else passed++;
      if (ev) begin
        total++; if (out_pc !== expPc) $display("FAIL rnd_out_pc cyc %0d got %h want %h", c, out_pc, expPc); else passed++;
        total++; if (out_instr !== mem(expPc)) $display("FAIL rnd_out_instr cyc %0d got %h want %h", c, out_instr, mem(expPc)); else passed++;
      end
      total++; if (out_exc !== 1'b0) $display("FAIL rnd_out_exc cyc %0d got %b want 0", c, out_exc); else passed++;
      total++; if (fetch_busy !== !hold) $display("FAIL rnd_busy cyc %0d got %b want %b", c, fetch_busy, !hold); else passed++;
      if (rv) begin
        expPc = rp;
        hold = 0;
        if (outstanding && !ok) dirty = 1;
      end else if (ev) begin
        if (st) hold = 1;
        else begin
          hold = 0;
          expPc = expPc + 64'd4;
        end
      end
      if (ok) begin
        outstanding = 0;
        dirty = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_discard();
    test_double_redirect();
    test_redirect_dataok_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
